axi_sram_slave: RTL and testbench

- AXI3 slave responder with a single-port word-organised memory behind it.
- Acts as the far end of the CPU's AXI master interface; it answers the read-address, read-data, write-address, write-data and write-response channels.
- Serves as the memory model for CPU-level simulation and as an on-chip RAM in the SoC.
- Supports one outstanding read and one outstanding write, running concurrently, with FIXED and INCR bursts.

---
 rtl/axi_sram_slave.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_axi_sram_slave.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave responder in front of a word-organised 32-bit SRAM
//
// One outstanding read and one outstanding write, running concurrently.
// FIXED and INCR bursts are served. WRAP and reserved bursts complete with SLVERR,
// return zero data and never touch memory.
// Optional feature: define AXI_SLV_DELAY_EN to insert DELAY wait cycles before the
// first R beat and before B (DELAY=0 then behaves as if the macro were undefined).
//
// Ports:
//   aclk, reset                 clock, asynchronous active-high reset
//   ar*/arvalid/arready         read address channel (arlock/arcache/arprot ignored)
//   rid/rdata/rresp/rlast       read data channel, rvalid/rready handshake
//   aw*/awvalid/awready         write address channel (awlock/awcache/awprot ignored)
//   wid/wdata/wstrb/wlast       write data channel, wvalid/wready handshake (wid ignored)
//   bid/bresp                   write response channel, bvalid/bready handshake
module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int DELAY  = 2
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [15:0] DELAY_CNT  = 16'(DELAY);

`ifdef AXI_SLV_DELAY_EN
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wstate_t;
    logic [15:0] rcnt;
    logic [15:0] wcnt_dly;
`else
    typedef enum logic {R_IDLE, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
`endif

    logic [31:0] mem [2**ADDR_W];

    function automatic logic [ADDR_W-1:0] word_idx(input logic [31:0] a);
        return a[ADDR_W+1:2];
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == BURST_INCR) ? a + (32'd1 << size) : a;
    endfunction

    // ---------------- read side ----------------
    rstate_t     rstate;
    logic [31:0] raddr;
    logic [31:0] raddr_nxt;
    logic [7:0]  rlen;
    logic [7:0]  rbeat;
    logic [2:0]  rsize;
    logic [1:0]  rburst;

    assign raddr_nxt = next_addr(raddr, rsize, rburst);

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            rstate  <= R_IDLE;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= '0;
            rdata   <= '0;
            rresp   <= '0;
            raddr   <= '0;
            rlen    <= '0;
            rbeat   <= '0;
            rsize   <= '0;
            rburst  <= '0;
`ifdef AXI_SLV_DELAY_EN
            rcnt    <= '0;
`endif
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        raddr   <= araddr;
                        rlen    <= arlen;
                        rsize   <= arsize;
                        rburst  <= arburst;
                        rbeat   <= '0;
                        rid     <= arid;
                        rlast   <= (arlen == 8'd0);
                        arready <= 1'b0;
                        // burst[1] set means WRAP or reserved: error response, no data
                        if (arburst[1]) begin
                            rdata <= '0;
                            rresp <= RESP_SLVERR;
                        end else begin
                            rdata <= mem[word_idx(araddr)];
                            rresp <= RESP_OKAY;
                        end
`ifdef AXI_SLV_DELAY_EN
                        if (DELAY_CNT != 16'd0) begin
                            rcnt   <= DELAY_CNT;
                            rstate <= R_WAIT;
                        end else begin
                            rvalid <= 1'b1;
                            rstate <= R_DATA;
                        end
`else
                        rvalid <= 1'b1;
                        rstate <= R_DATA;
`endif
                    end
                end
`ifdef AXI_SLV_DELAY_EN
                R_WAIT: begin
                    if (rcnt == 16'd1) begin
                        rvalid <= 1'b1;
                        rstate <= R_DATA;
                    end else begin
                        rcnt <= rcnt - 16'd1;
                    end
                end
`endif
                R_DATA: begin
                    // rvalid is high for the whole of R_DATA
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            raddr <= raddr_nxt;
                            rbeat <= rbeat + 8'd1;
                            rlast <= ((rbeat + 8'd1) == rlen);
                            if (!rburst[1]) begin
                                rdata <= mem[word_idx(raddr_nxt)];
                            end
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- write side ----------------
    wstate_t     wstate;
    logic [31:0] waddr;
    logic [7:0]  wlen;
    logic [8:0]  wcnt;
    logic [2:0]  wsize;
    logic [1:0]  wburst;
    logic        wr_en;

    // Beats beyond len are handshaken but dropped; error bursts never write.
    assign wr_en = (wstate == W_DATA) && wvalid && (wcnt <= {1'b0, wlen}) && !wburst[1];

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            wstate  <= W_IDLE;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= '0;
            bresp   <= '0;
            waddr   <= '0;
            wlen    <= '0;
            wcnt    <= '0;
            wsize   <= '0;
            wburst  <= '0;
`ifdef AXI_SLV_DELAY_EN
            wcnt_dly <= '0;
`endif
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        waddr   <= awaddr;
                        wlen    <= awlen;
                        wsize   <= awsize;
                        wburst  <= awburst;
                        wcnt    <= '0;
                        bid     <= awid;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        waddr <= next_addr(waddr, wsize, wburst);
                        // saturate so an over-long burst cannot wrap back to a "correct" count
                        if (wcnt != 9'h1FF) begin
                            wcnt <= wcnt + 9'd1;
                        end
                        if (wlast) begin
                            wready <= 1'b0;
                            // this beat makes the count wcnt+1, which must equal len+1
                            bresp  <= (wburst[1] || (wcnt != {1'b0, wlen})) ? RESP_SLVERR : RESP_OKAY;
`ifdef AXI_SLV_DELAY_EN
                            if (DELAY_CNT != 16'd0) begin
                                wcnt_dly <= DELAY_CNT;
                                wstate   <= W_WAIT;
                            end else begin
                                bvalid <= 1'b1;
                                wstate <= W_RESP;
                            end
`else
                            bvalid <= 1'b1;
                            wstate <= W_RESP;
`endif
                        end
                    end
                end
`ifdef AXI_SLV_DELAY_EN
                W_WAIT: begin
                    if (wcnt_dly == 16'd1) begin
                        bvalid <= 1'b1;
                        wstate <= W_RESP;
                    end else begin
                        wcnt_dly <= wcnt_dly - 16'd1;
                    end
                end
`endif
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Memory array is deliberately not reset. Reads above sample the old word
    // on a same-cycle collision, giving read-first behaviour.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[word_idx(waddr)][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    logic unused;
    assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, DELAY_CNT};

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave
module tb_axi_sram_slave;

    localparam int ADDR_W = 16;
    localparam int DELAY  = 2;
`ifdef AXI_SLV_DELAY_EN
    localparam int LAT = 1 + DELAY;
`else
    localparam int LAT = 1;
`endif

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;

    axi_sram_slave #(.ADDR_W(ADDR_W), .DELAY(DELAY)) dut (
        .aclk(aclk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(2'b00), .arcache(4'h3), .arprot(3'b000),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(2'b01), .awcache(4'h0), .awprot(3'b111),
        .awvalid(awvalid), .awready(awready),
        .wid(4'hA), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_pass = 0;
    int timeouts = 0;

    // reference memory: word value plus which bytes have ever been written
    logic [31:0] model [int unsigned];
    logic [3:0]  known [int unsigned];

    logic [31:0] wq_data [$];
    logic [3:0]  wq_strb [$];
    logic [31:0] rq_data [$];
    logic [1:0]  rq_resp [$];
    logic        rq_last [$];
    logic [3:0]  rq_id [$];
    int          r_lat, r_hold_err, r_arready_err;
    logic        r_after_rvalid, r_after_arready;
    int          b_lat;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic int unsigned beat_word(input logic [31:0] addr, input int k,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] a;
        a = (burst == 2'b00) ? addr : addr + 32'(k) * (32'd1 << size);
        return (a >> 2) & ((32'd1 << ADDR_W) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_data(input int unsigned w);
        return model.exists(w) ? model[w] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_mask(input int unsigned w);
        logic [3:0]  m;
        logic [31:0] r;
        m = known.exists(w) ? known[w] : 4'h0;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int last_at);
        int unsigned w;
        logic [31:0] d;
        logic [3:0]  m;
        if (burst[1]) return;
        for (int k = 0; k <= last_at; k++) begin
            if (k <= int'(len)) begin
                w = beat_word(addr, k, size, burst);
                d = exp_data(w);
                m = known.exists(w) ? known[w] : 4'h0;
                for (int b = 0; b < 4; b++) begin
                    if (wq_strb[k][b]) begin
                        d[8*b +: 8] = wq_data[k][8*b +: 8];
                        m[b] = 1'b1;
                    end
                end
                model[w] = d;
                known[w] = m;
            end
        end
    endtask

    // drives AW, then wq_* beats 0..last_at with wlast on last_at, then collects B
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int last_at);
        int g;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        g = 0;
        while (!awready && g < 100) begin tick(); g++; end
        if (g >= 100) timeouts++;
        tick();
        awvalid = 1'b0;
        for (int k = 0; k <= last_at; k++) begin
            wdata = wq_data[k]; wstrb = wq_strb[k]; wlast = (k == last_at); wvalid = 1'b1;
            g = 0;
            while (!wready && g < 100) begin tick(); g++; end
            if (g >= 100) timeouts++;
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        b_lat = 1;
        while (!bvalid && b_lat < 100) begin tick(); b_lat++; end
        if (!bvalid) timeouts++;
        b_id = bid; b_resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        model_write(addr, len, size, burst, last_at);
    endtask

    // mode 0: rready always 1, mode 1: toggles 1,0,1,0..., mode 2: random
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
        int   g;
        logic done, fire;
        logic [39:0] snap;
        rq_data.delete(); rq_resp.delete(); rq_last.delete(); rq_id.delete();
        r_hold_err = 0; r_arready_err = 0;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 100) begin tick(); g++; end
        if (g >= 100) timeouts++;
        tick();
        arvalid = 1'b0;
        r_lat = 1;
        while (!rvalid && r_lat < 100) begin tick(); r_lat++; end
        done = 1'b0;
        g = 0;
        while (!done && g < 600) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = (g % 2 == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (arready) r_arready_err++;
            snap = {rvalid, rlast, rresp, rid, rdata};
            fire = rvalid && rready;
            if (fire) begin
                rq_data.push_back(rdata); rq_resp.push_back(rresp);
                rq_last.push_back(rlast); rq_id.push_back(rid);
                done = rlast;
            end
            tick();
            g++;
            if (!fire && snap[39] && (snap !== {rvalid, rlast, rresp, rid, rdata})) r_hold_err++;
        end
        if (!done) timeouts++;
        rready = 1'b0;
        r_after_rvalid = rvalid;
        r_after_arready = arready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++;
        if ({arready, awready, wready, rvalid, rlast, bvalid} !== 6'b110000)
            $display("FAIL reset_ctrl: got %b expected 110000", {arready, awready, wready, rvalid, rlast, bvalid});
        else n_pass++;
        n_checks++;
        if ({rid, rdata, rresp, bid, bresp} !== 44'h0)
            $display("FAIL reset_data: got %h expected 0", {rid, rdata, rresp, bid, bresp});
        else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_beat();
        // W presented before AW must not be accepted
        wvalid = 1'b1; wdata = 32'h0BAD0BAD; wstrb = 4'hF; wlast = 1'b1;
        tick(); tick();
        n_checks++;
        if (wready !== 1'b0) $display("FAIL w_before_aw: wready got %b expected 0", wready); else n_pass++;
        wvalid = 1'b0; wlast = 1'b0;
        wq_data = '{32'hDEADBEEF}; wq_strb = '{4'hF};
        do_write(4'd3, 32'h1C, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if ({b_id, b_resp} !== {4'd3, 2'b00}) $display("FAIL single_b: got %h expected %h", {b_id, b_resp}, {4'd3, 2'b00}); else n_pass++;
        n_checks++;
        if (b_lat !== LAT) $display("FAIL b_latency: got %0d expected %0d", b_lat, LAT); else n_pass++;
        n_checks++;
        if (bvalid !== 1'b0) $display("FAIL b_drop: bvalid got %b expected 0", bvalid); else n_pass++;
        do_read(4'd5, 32'h1C, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if (r_lat !== LAT) $display("FAIL r_latency: got %0d expected %0d", r_lat, LAT); else n_pass++;
        n_checks++;
        if (rq_data.size() != 1 || {rq_data[0], rq_id[0], rq_last[0], rq_resp[0]} !== {32'hDEADBEEF, 4'd5, 1'b1, 2'b00})
            $display("FAIL single_r: got %0d beats first %h expected 1 beat deadbeef/5/1/0",
                     rq_data.size(), rq_data.size() > 0 ? rq_data[0] : 32'h0);
        else n_pass++;
    endtask

    task automatic test_partial_strobe();
        wq_data = '{32'h11223344}; wq_strb = '{4'hF};
        do_write(4'd1, 32'h20, 8'd0, 3'd2, 2'b01, 0);
        wq_data = '{32'hAABBCCDD}; wq_strb = '{4'b0101};
        do_write(4'd2, 32'h22, 8'd0, 3'd2, 2'b01, 0);
        do_read(4'd7, 32'h20, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if (rq_data.size() != 1 || rq_data[0] !== 32'h11BB33DD)
            $display("FAIL partial_strobe: got %h expected 11bb33dd", rq_data.size() > 0 ? rq_data[0] : 32'h0);
        else n_pass++;
    endtask

    task automatic test_incr_read_burst();
        wq_data.delete(); wq_strb.delete();
        for (int k = 0; k < 4; k++) begin wq_data.push_back($urandom); wq_strb.push_back(4'hF); end
        do_write(4'd4, 32'h100, 8'd3, 3'd2, 2'b01, 3);
        do_read(4'd9, 32'h100, 8'd3, 3'd2, 2'b01, 1);
        n_checks++;
        if (rq_data.size() != 4) $display("FAIL incr_beats: got %0d expected 4", rq_data.size()); else n_pass++;
        for (int k = 0; k < rq_data.size(); k++) begin
            n_checks++;
            if ({rq_data[k], rq_last[k], rq_id[k]} !== {exp_data(32'h40 + k), (k == 3), 4'd9})
                $display("FAIL incr_beat%0d: got %h/%b expected %h/%b", k, rq_data[k], rq_last[k], exp_data(32'h40 + k), k == 3);
            else n_pass++;
        end
        n_checks++;
        if (r_hold_err !== 0) $display("FAIL r_hold: got %0d changes expected 0", r_hold_err); else n_pass++;
        n_checks++;
        if (r_arready_err !== 0) $display("FAIL arready_busy: got %0d expected 0", r_arready_err); else n_pass++;
        n_checks++;
        if ({r_after_rvalid, r_after_arready} !== 2'b01)
            $display("FAIL r_end: rvalid/arready got %b expected 01", {r_after_rvalid, r_after_arready});
        else n_pass++;
    endtask

    task automatic test_fixed_and_early_wlast();
        wq_data = '{32'd1, 32'd2, 32'd3}; wq_strb = '{4'hF, 4'hF, 4'hF};
        do_write(4'd6, 32'h200, 8'd2, 3'd2, 2'b00, 2);
        n_checks++;
        if ({b_id, b_resp} !== {4'd6, 2'b00}) $display("FAIL fixed_b: got %h expected %h", {b_id, b_resp}, {4'd6, 2'b00}); else n_pass++;
        do_read(4'd1, 32'h200, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if (rq_data.size() != 1 || rq_data[0] !== 32'd3)
            $display("FAIL fixed_data: got %h expected 3", rq_data.size() > 0 ? rq_data[0] : 32'h0);
        else n_pass++;
        wq_data = '{$urandom, $urandom}; wq_strb = '{4'hF, 4'hF};
        do_write(4'd8, 32'h300, 8'd3, 3'd2, 2'b01, 1);
        n_checks++;
        if ({b_id, b_resp} !== {4'd8, 2'b10}) $display("FAIL early_wlast: got %h expected %h", {b_id, b_resp}, {4'd8, 2'b10}); else n_pass++;
        do_read(4'd2, 32'h300, 8'd1, 3'd2, 2'b01, 2);
        n_checks++;
        if (rq_data.size() != 2 || rq_data[0] !== exp_data(32'hC0) || rq_data[1] !== exp_data(32'hC1))
            $display("FAIL early_data: got %0d beats expected 2 matching written words", rq_data.size());
        else n_pass++;
    endtask

    task automatic test_concurrent_random();
        logic [31:0] p_addr = 32'h100;
        logic [7:0]  p_len = 8'd3;
        logic [2:0]  p_size = 3'd2;
        logic [1:0]  p_burst = 2'b01;
        for (int it = 0; it < 12; it++) begin
            logic [31:0] n_addr;
            logic [7:0]  n_len;
            logic [2:0]  n_size;
            logic [1:0]  n_burst;
            logic [3:0]  wid_r, rid_r;
            n_addr = 32'h4000 + 32'(it) * 32'h400 + 32'($urandom_range(0, 15));
            n_len = 8'($urandom_range(0, 7));
            n_size = 3'($urandom_range(0, 2));
            n_burst = 2'($urandom_range(0, 1));
            wid_r = 4'($urandom); rid_r = 4'($urandom);
            wq_data.delete(); wq_strb.delete();
            for (int k = 0; k <= int'(n_len); k++) begin
                wq_data.push_back($urandom); wq_strb.push_back(4'($urandom));
            end
            fork
                do_write(wid_r, n_addr, n_len, n_size, n_burst, int'(n_len));
                do_read(rid_r, p_addr, p_len, p_size, p_burst, 2);
            join
            n_checks++;
            if ({b_id, b_resp} !== {wid_r, 2'b00}) $display("FAIL conc_b%0d: got %h expected %h", it, {b_id, b_resp}, {wid_r, 2'b00}); else n_pass++;
            n_checks++;
            if (rq_data.size() != int'(p_len) + 1) $display("FAIL conc_beats%0d: got %0d expected %0d", it, rq_data.size(), p_len + 1); else n_pass++;
            for (int k = 0; k < rq_data.size(); k++) begin
                int unsigned w;
                w = beat_word(p_addr, k, p_size, p_burst);
                n_checks++;
                if (((rq_data[k] & exp_mask(w)) !== (exp_data(w) & exp_mask(w))) ||
                    ({rq_id[k], rq_resp[k], rq_last[k]} !== {rid_r, 2'b00, k == int'(p_len)}))
                    $display("FAIL conc_r%0d_%0d: got %h id %h last %b expected %h id %h", it, k,
                             rq_data[k], rq_id[k], rq_last[k], exp_data(w) & exp_mask(w), rid_r);
                else n_pass++;
            end
            p_addr = n_addr; p_len = n_len; p_size = n_size; p_burst = n_burst;
        end
    endtask

    task automatic test_wrap();
        wq_data = '{32'h55555555}; wq_strb = '{4'hF};
        do_write(4'd9, 32'h1C, 8'd0, 3'd2, 2'b10, 0);
        n_checks++;
        if ({b_id, b_resp} !== {4'd9, 2'b10}) $display("FAIL wrap_b: got %h expected %h", {b_id, b_resp}, {4'd9, 2'b10}); else n_pass++;
        do_read(4'hC, 32'h1C, 8'd1, 3'd2, 2'b10, 0);
        n_checks++;
        if (rq_data.size() != 2 || {rq_data[0], rq_resp[0], rq_last[0], rq_data[1], rq_resp[1], rq_last[1], rq_id[1]} !==
            {32'h0, 2'b10, 1'b0, 32'h0, 2'b10, 1'b1, 4'hC})
            $display("FAIL wrap_r: got %0d beats expected 2 zero beats with slverr", rq_data.size());
        else n_pass++;
        do_read(4'd3, 32'h1C, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if (rq_data.size() != 1 || rq_data[0] !== 32'hDEADBEEF)
            $display("FAIL wrap_nowrite: got %h expected deadbeef", rq_data.size() > 0 ? rq_data[0] : 32'h0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int g;
        arid = 4'd2; araddr = 32'h4000; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        g = 0;
        while (!arready && g < 100) begin tick(); g++; end
        tick();
        arvalid = 1'b0;
        g = 0;
        while (!rvalid && g < 100) begin tick(); g++; end
        if (g >= 100) timeouts++;
        rready = 1'b1;
        tick();
        // second beat is now on the bus
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({rvalid, arready} !== 2'b01) $display("FAIL reset_abort: rvalid/arready got %b expected 01", {rvalid, arready}); else n_pass++;
        rready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        do_read(4'd6, 32'h1C, 8'd0, 3'd2, 2'b01, 0);
        n_checks++;
        if (rq_data.size() != 1 || {rq_data[0], rq_id[0]} !== {32'hDEADBEEF, 4'd6})
            $display("FAIL after_reset: got %h expected deadbeef", rq_data.size() > 0 ? rq_data[0] : 32'h0);
        else n_pass++;
        n_checks++;
        if (r_lat !== LAT) $display("FAIL after_reset_lat: got %0d expected %0d", r_lat, LAT); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_partial_strobe();
        test_incr_read_burst();
        test_fixed_and_early_wlast();
        test_concurrent_random();
        test_wrap();
        test_reset_mid_burst();
        n_checks++;
        if (timeouts !== 0) $display("FAIL timeouts: got %0d expected 0", timeouts); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
